alu_request_scheduler: RTL and testbench
========================================

Name: alu_request_scheduler

Overview:
- Shares the single ALU datapath between NUM_REQ independent requesters.
- Grants one operation at a time using round-robin arbitration, drives the ALU input side and waits for the ALU output side.
- Routes the result back to the granted requester, with a watchdog timeout.
- Sits between the requester fabric and the ALU DUT; its ALU ports map one-to-one onto the ALU_in and ALU_out agent interfaces.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, width of operands a/b; result width is 2*DATA_W.
- TIMEOUT, 64, cycles waited for alu_valid before an error completion (>=4).

Ports:
- clk  in  1  single clock; everything is sampled on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  request pending, one bit per requester.
- req_op  in  3*NUM_REQ  op code per requester; slice i = [3i+2:3i].
- req_a  in  DATA_W*NUM_REQ  operand a per requester.
- req_b  in  DATA_W*NUM_REQ  operand b per requester.
- req_ready  out  NUM_REQ  one-hot; request accepted this cycle.
- rsp_valid  out  NUM_REQ  one-hot, single-cycle completion strobe.
- rsp_result  out  2*DATA_W  shared result bus, qualified by rsp_valid.
- rsp_error  out  1  completion is an error (timeout or illegal op).
- alu_op  out  3  op code to ALU.
- alu_a  out  DATA_W  operand a to ALU.
- alu_b  out  DATA_W  operand b to ALU.
- alu_enable  out  1  single-cycle issue strobe.
- alu_ready  in  1  ALU can accept an op.
- alu_valid  in  1  ALU result valid.
- alu_result  in  2*DATA_W  ALU result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Op codes: 0 no_op, 1 add, 2 and, 3 xor, 4 mul, 7 rst_op; 5 and 6 are illegal.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant g = first requester with req_valid set, searching from last_grant+1 with wrap-around.
  - req_ready[g]=1 combinationally only when state==IDLE and any req_valid is set.
  - Accept occurs on that edge: op, a, b and g are registered and last_grant<=g.
  - Routing after accept: ops 1-4 and 7 go to ISSUE; op 0 goes to RESP with result 0, error 0; ops 5/6 go to RESP with result 0, error 1. No ALU traffic for ops 0, 5 or 6.
- ISSUE:
  - Wait in ISSUE while alu_ready=0; alu_enable stays 0.
  - When alu_ready=1: alu_enable=1 for exactly that cycle, with alu_op/a/b driven from registers.
  - Next state: op 7 goes to RESP with result 0, error 0, since the ALU produces no valid for rst_op. Other ops go to WAIT and clear the timer.
- WAIT:
  - Timer increments each cycle.
  - alu_valid=1: capture alu_result, go to RESP with error 0.
  - Timer reaches TIMEOUT-1 without valid: go to RESP with result 0, error 1.
  - If valid and timeout coincide, valid wins.
- RESP: rsp_valid[g]=1 for one cycle with rsp_result/rsp_error, then IDLE. Responses have no backpressure.
- Latency, zero ALU wait: accept at T, alu_enable at T+1, alu_valid at T+k, rsp_valid at T+k+1. Back-to-back accepts are at best 4 cycles apart.
- Outside the issue strobe, alu_op/a/b hold their last values. alu_valid outside WAIT is ignored.
- Requester changes in IDLE: deasserting req_valid before accept is legal. Arbitration re-evaluates every IDLE cycle.
- Fairness: a continuously requesting requester is served within NUM_REQ grants.
- Reset:
  - Synchronous; takes effect on the next edge from any state, aborting in-flight ops with no response.
  - State<=IDLE, last_grant<=NUM_REQ-1 so requester 0 wins first.
  - All outputs 0, timer 0, registered op/a/b/result 0.

Decomposition:
- alu_sched_pkg holds:
  - alu_op_t enum (NO_OP=0, ADD=1, AND=2, XOR=3, MUL=4, RST=7).
  - sched_state_t enum.
  - function is_legal_op.
- Sub-module rr_arbiter (parameter N): inputs req[N], last[$clog2(N)]; outputs gnt_onehot and gnt_idx. Purely combinational, instantiated once.

Test Plan:
- Single add: req0 valid, op=1, a=8'h12, b=8'h34; ALU returns valid 3 cycles after enable with 16'h0046. Expect alu_enable exactly once, rsp_valid=4'b0001, result 16'h0046, error 0.
- Round-robin: all four requesters hold req_valid after reset. Expect grant order 0,1,2,3,0,1; exactly one req_ready per accept.
- Timeout: req2 mul, ALU never asserts valid. Expect rsp_valid[2] exactly TIMEOUT cycles after entering WAIT, result 0, error 1.
- Local completions: req1 op=0 gives rsp at accept+1, error 0, no alu_enable. req3 op=5 gives error 1, no alu_enable. req0 op=7 gives one alu_enable and rsp the next cycle, error 0.
- Backpressure: alu_ready low for 10 cycles after accept. Expect alu_enable stays 0 and state stays ISSUE; enable fires on the first ready cycle.
- Reset in WAIT: assert rst mid-wait. Expect no rsp_valid, busy=0 next cycle, and requester 0 wins the next arbitration.

Source files
------------

// File: rtl/alu_request_scheduler_pkg.sv
// Shared types and helpers for the ALU request scheduler.
package alu_sched_pkg;

  typedef enum logic [2:0] {
    NO_OP = 3'd0,
    ADD   = 3'd1,
    AND   = 3'd2,
    XOR   = 3'd3,
    MUL   = 3'd4,
    RST   = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sched_state_t;

  // Codes 5 and 6 have no ALU meaning and complete locally with an error.
  function automatic logic is_legal_op(input logic [2:0] op);
    return (op != 3'd5) && (op != 3'd6);
  endfunction

endpackage

// File: rtl/alu_request_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after `last`, wrapping.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         gnt_onehot,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int LW = $clog2(N);

  logic [LW-1:0] cand;
  logic          found;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    cand       = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = LW'((32'(last) + i) % N);
      if (!found && req[cand]) begin
        found            = 1'b1;
        gnt_idx          = cand;
        gnt_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_request_scheduler.sv
// Shares one ALU between NUM_REQ requesters: round-robin accept, issue,
// wait for the result (with watchdog), then return a one-cycle response.
module alu_request_scheduler
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [3*NUM_REQ-1:0]      req_op,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [2*DATA_W-1:0]       rsp_result,
  output logic                      rsp_error,
  output logic [2:0]                alu_op,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic                      alu_enable,
  input  logic                      alu_ready,
  input  logic                      alu_valid,
  input  logic [2*DATA_W-1:0]       alu_result,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT - 1);

  sched_state_t state, state_nxt;

  logic [IDX_W-1:0]    last_grant, gnt_q, gnt_idx;
  logic [NUM_REQ-1:0]  gnt_onehot;
  logic                gnt_any;
  logic [2:0]          sel_op, op_q, op_h;
  logic [DATA_W-1:0]   sel_a, sel_b, a_q, b_q, a_h, b_h;
  logic [2*DATA_W-1:0] result_q;
  logic                error_q;
  logic [TMR_W-1:0]    timer;
  logic                issue;
  logic                local_done;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .req        (req_valid),
    .last       (last_grant),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx)
  );

  assign gnt_any = |req_valid;

  always_comb begin
    sel_op = req_op[32'(gnt_idx) * 3 +: 3];
    sel_a  = req_a[32'(gnt_idx) * DATA_W +: DATA_W];
    sel_b  = req_b[32'(gnt_idx) * DATA_W +: DATA_W];
  end

  // no_op and illegal codes complete without touching the ALU
  assign local_done = (sel_op == NO_OP) || !is_legal_op(sel_op);
  assign issue      = (state == ISSUE) && alu_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (gnt_any) state_nxt = local_done ? RESP : ISSUE;
      ISSUE: if (alu_ready) state_nxt = (op_q == RST) ? RESP : WAIT;
      WAIT:  if (alu_valid || (timer == TMR_MAX)) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= LAST_RST;
      gnt_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_h       <= '0;
      a_h        <= '0;
      b_h        <= '0;
      result_q   <= '0;
      error_q    <= 1'b0;
      timer      <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_any) begin
          op_q       <= sel_op;
          a_q        <= sel_a;
          b_q        <= sel_b;
          gnt_q      <= gnt_idx;
          last_grant <= gnt_idx;
          result_q   <= '0;
          error_q    <= !is_legal_op(sel_op);
        end
        ISSUE: if (alu_ready) begin
          op_h  <= op_q;
          a_h   <= a_q;
          b_h   <= b_q;
          timer <= '0;
        end
        WAIT: begin
          timer <= timer + TMR_W'(1);
          // a result arriving on the last watchdog cycle still wins
          if (alu_valid)               result_q <= alu_result;
          else if (timer == TMR_MAX)   error_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ALU operand bus shows registered operands during the strobe and holds
  // the last issued values otherwise.
  assign alu_enable = issue;
  assign alu_op     = issue ? op_q : op_h;
  assign alu_a      = issue ? a_q  : a_h;
  assign alu_b      = issue ? b_q  : b_h;

  assign req_ready  = (state == IDLE) ? gnt_onehot : '0;
  assign rsp_valid  = (state == RESP) ? (NUM_REQ'(1) << gnt_q) : '0;
  assign rsp_result = (state == RESP) ? result_q : '0;
  assign rsp_error  = (state == RESP) && error_q;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_request_scheduler.sv
// Self-checking bench for alu_request_scheduler: vector table, directed
// multi-cycle sequences and a randomized run against a transaction model.
module tb_alu_request_scheduler;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int TO = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [3*NR-1:0]  req_op = '0;
  logic [DW*NR-1:0] req_a = '0;
  logic [DW*NR-1:0] req_b = '0;
  logic [NR-1:0]    req_ready, rsp_valid;
  logic [2*DW-1:0]  rsp_result;
  logic             rsp_error;
  logic [2:0]       alu_op;
  logic [DW-1:0]    alu_a, alu_b;
  logic             alu_enable, busy;
  logic             alu_ready = 1'b1;
  logic             alu_valid = 1'b0;
  logic [2*DW-1:0]  alu_result = '0;

  alu_request_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_error(rsp_error),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_enable(alu_enable),
    .alu_ready(alu_ready), .alu_valid(alu_valid), .alu_result(alu_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [2:0] r_op [NR];
  logic [7:0] r_a  [NR];
  logic [7:0] r_b  [NR];

  // per-cycle snapshot and event records
  logic [NR-1:0]   s_req_ready, s_rsp_valid;
  logic [15:0]     s_rsp_result;
  logic            s_rsp_error, s_en, s_busy;
  logic [2:0]      s_alu_op;
  logic [7:0]      s_alu_a, s_alu_b;
  int acc_count, acc_idx, acc_cyc, enable_cnt, last_en_cyc, rsp_count, rsp_cyc;
  logic            rsp_seen;
  logic [NR-1:0]   rsp_vec;
  logic [15:0]     rsp_res;
  logic            rsp_err;

  // ALU stand-in
  int          stub_cnt = 0;
  int          stub_lat = 3;
  logic        stub_drop = 1'b0;
  logic        drop_next = 1'b0;
  logic [15:0] stub_res = '0;

  // transaction-level reference model for the random phase
  logic        rand_mode = 1'b0;
  logic        m_busy = 1'b0;
  int          m_last = NR - 1;
  int          m_idx, m_age;
  logic [15:0] m_res;
  logic        m_err;

  function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd1: return 16'(a) + 16'(b);
      3'd2: return {8'h00, a & b};
      3'd3: return {8'h00, a ^ b};
      3'd4: return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  function automatic int rr_pick(input int last, input logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++) begin
      int c = (last + k) % NR;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic int idx_of(input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
  endtask

  task automatic pack();
    for (int k = 0; k < NR; k++) begin
      req_op[3*k +: 3] = r_op[k];
      req_a[8*k +: 8]  = r_a[k];
      req_b[8*k +: 8]  = r_b[k];
    end
  endtask

  task automatic set_req(input int idx, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    r_op[idx] = op; r_a[idx] = a; r_b[idx] = b;
    pack();
  endtask

  task automatic model_check();
    int e;
    if (!m_busy) begin
      e = rr_pick(m_last, req_valid);
      chk("rnd_idle_rsp", 32'(s_rsp_valid), 0);
      if (e < 0) chk("rnd_idle_ready", 32'(s_req_ready), 0);
      else begin
        chk("rnd_grant", 32'(s_req_ready), 32'(1) << e);
        m_busy = 1'b1; m_last = e; m_idx = e; m_age = 0;
        drop_next = ($urandom_range(0, 15) == 0);
        stub_lat  = $urandom_range(1, 5);
        case (r_op[e])
          3'd1, 3'd2, 3'd3, 3'd4: begin
            m_res = drop_next ? 16'h0 : alu_fn(r_op[e], r_a[e], r_b[e]);
            m_err = drop_next;
          end
          3'd5, 3'd6: begin m_res = 16'h0; m_err = 1'b1; end
          default:    begin m_res = 16'h0; m_err = 1'b0; end
        endcase
      end
    end else begin
      chk("rnd_busy_ready", 32'(s_req_ready), 0);
      if (s_rsp_valid != '0) begin
        chk("rnd_rsp_vec", 32'(s_rsp_valid), 32'(1) << m_idx);
        chk("rnd_rsp_result", 32'(s_rsp_result), 32'(m_res));
        chk("rnd_rsp_error", 32'(s_rsp_error), 32'(m_err));
        m_busy = 1'b0;
      end else begin
        m_age++;
        if (m_age > TO + 100) begin
          tests++; fails++;
          $display("FAIL rnd_no_response: got none after %0d cycles, required one", m_age);
          summary();
          $fatal(1, "no response");
        end
      end
    end
  endtask

  task automatic step();
    #1;
    s_req_ready = req_ready; s_rsp_valid = rsp_valid; s_rsp_result = rsp_result;
    s_rsp_error = rsp_error; s_en = alu_enable; s_busy = busy;
    s_alu_op = alu_op; s_alu_a = alu_a; s_alu_b = alu_b;
    if (s_req_ready != '0) begin
      acc_count++; acc_idx = idx_of(s_req_ready); acc_cyc = cyc;
    end
    if (s_en) begin
      enable_cnt++; last_en_cyc = cyc;
      stub_res = alu_fn(alu_op, alu_a, alu_b); stub_drop = drop_next; stub_cnt = stub_lat;
    end
    if (s_rsp_valid != '0) begin
      rsp_seen = 1'b1; rsp_count++; rsp_cyc = cyc;
      rsp_vec = s_rsp_valid; rsp_res = s_rsp_result; rsp_err = s_rsp_error;
    end
    if (rand_mode) model_check();
    @(posedge clk); #1;
    cyc++;
    alu_valid  = 1'b0;
    alu_result = 16'($urandom);
    if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0 && !stub_drop) begin
        alu_valid = 1'b1; alu_result = stub_res;
      end
    end
  endtask

  task automatic clear_rec();
    rsp_seen = 1'b0; enable_cnt = 0; acc_count = 0;
  endtask

  task automatic run_to_rsp(input int bound);
    int n = 0;
    while (!rsp_seen && n < bound) begin
      step();
      req_valid = req_valid & ~s_req_ready;
      n++;
    end
    if (!rsp_seen) begin
      tests++; fails++;
      $display("FAIL rsp_wait: got no rsp_valid within %0d cycles, required one", bound);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; stub_cnt = 0;
    step(); step();
    rst = 1'b0; stub_cnt = 0; drop_next = 1'b0; alu_valid = 1'b0;
  endtask

  typedef struct {
    int         idx;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    int         lat;
    logic [15:0] res;
    logic       err;
    int         en;
    int         cycles;
  } vec_t;

  vec_t vecs[10];
  int   exp_order[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    #2000000;
    tests++; fails++;
    $display("FAIL watchdog: simulation did not finish within time limit");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n, c;
    vecs[0] = '{0, 3'd1, 8'h12, 8'h34, 3, 16'h0046, 1'b0, 1, 5};
    vecs[1] = '{1, 3'd2, 8'hF0, 8'h3C, 3, 16'h0030, 1'b0, 1, 5};
    vecs[2] = '{2, 3'd3, 8'hF0, 8'h3C, 3, 16'h00CC, 1'b0, 1, 5};
    vecs[3] = '{3, 3'd4, 8'hFF, 8'hFF, 3, 16'hFE01, 1'b0, 1, 5};
    vecs[4] = '{1, 3'd0, 8'h55, 8'h66, 3, 16'h0000, 1'b0, 0, 1};
    vecs[5] = '{3, 3'd5, 8'h55, 8'h66, 3, 16'h0000, 1'b1, 0, 1};
    vecs[6] = '{2, 3'd6, 8'h01, 8'h02, 3, 16'h0000, 1'b1, 0, 1};
    vecs[7] = '{0, 3'd7, 8'h11, 8'h22, 3, 16'h0000, 1'b0, 1, 2};
    vecs[8] = '{0, 3'd1, 8'hFF, 8'h01, 1, 16'h0100, 1'b0, 1, 3};
    vecs[9] = '{2, 3'd4, 8'h10, 8'h10, 2, 16'h0100, 1'b0, 1, 4};
    for (int i = 0; i < NR; i++) begin r_op[i] = '0; r_a[i] = '0; r_b[i] = '0; end

    // reset state
    do_reset();
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_alu_enable", 32'(alu_enable), 0);
    chk("rst_alu_bus", {11'h0, alu_op, alu_a, alu_b}, 0);

    // single-requester vector table
    for (int i = 0; i < 10; i++) begin
      clear_rec();
      stub_lat = vecs[i].lat; drop_next = 1'b0; alu_ready = 1'b1;
      set_req(vecs[i].idx, vecs[i].op, vecs[i].a, vecs[i].b);
      req_valid = NR'(1) << vecs[i].idx;
      run_to_rsp(100);
      chk($sformatf("vec%0d_rsp_vec", i), 32'(rsp_vec), 32'(1) << vecs[i].idx);
      chk($sformatf("vec%0d_result", i), 32'(rsp_res), 32'(vecs[i].res));
      chk($sformatf("vec%0d_error", i), 32'(rsp_err), 32'(vecs[i].err));
      chk($sformatf("vec%0d_enables", i), enable_cnt, vecs[i].en);
      chk($sformatf("vec%0d_latency", i), rsp_cyc - acc_cyc, vecs[i].cycles);
      chk($sformatf("vec%0d_accepts", i), acc_count, 1);
      step(); step();
    end

    // round-robin with every requester holding its request
    do_reset();
    clear_rec(); stub_lat = 1; alu_ready = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 3'd1, 8'(i), 8'h01);
    req_valid = '1;
    k = 0; n = 0;
    while (k < 6 && n < 200) begin
      step(); n++;
      if (s_req_ready != '0) begin
        chk($sformatf("rr_onehot%0d", k), $countones(s_req_ready), 1);
        chk($sformatf("rr_grant%0d", k), acc_idx, exp_order[k]);
        k++;
      end
    end
    chk("rr_grant_count", k, 6);
    req_valid = '0;
    for (int i = 0; i < 6; i++) step();

    // watchdog timeout
    clear_rec(); drop_next = 1'b1; stub_lat = 2;
    set_req(2, 3'd4, 8'h03, 8'h05);
    req_valid = 4'b0100;
    run_to_rsp(TO + 20);
    chk("to_rsp_vec", 32'(rsp_vec), 32'h4);
    chk("to_result", 32'(rsp_res), 0);
    chk("to_error", 32'(rsp_err), 1);
    chk("to_delay", rsp_cyc - last_en_cyc, TO + 1);
    chk("to_enables", enable_cnt, 1);
    drop_next = 1'b0;
    step();

    // ALU backpressure
    clear_rec(); stub_lat = 2; alu_ready = 1'b0;
    set_req(1, 3'd1, 8'h21, 8'h43);
    req_valid = 4'b0010;
    step(); req_valid = req_valid & ~s_req_ready;
    chk("bp_accept", acc_count, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("bp_no_enable%0d", i), 32'(s_en), 0);
      chk($sformatf("bp_busy%0d", i), 32'(s_busy), 1);
      chk($sformatf("bp_hold_a%0d", i), 32'(s_alu_a), 32'h03);
    end
    alu_ready = 1'b1;
    step();
    chk("bp_enable", 32'(s_en), 1);
    chk("bp_alu_bus", {8'h0, 5'h0, s_alu_op, s_alu_a, s_alu_b}, {8'h0, 5'h0, 3'd1, 8'h21, 8'h43});
    step();
    chk("bp_hold_after", {s_alu_a, s_alu_b}, 16'h2143);
    run_to_rsp(20);
    chk("bp_result", 32'(rsp_res), 32'h0064);
    chk("bp_error", 32'(rsp_err), 0);
    step();

    // reset while waiting on the ALU
    clear_rec(); drop_next = 1'b1; stub_lat = 2; alu_ready = 1'b1;
    set_req(0, 3'd1, 8'h01, 8'h02);
    req_valid = 4'b0001;
    step(); req_valid = '0;
    step();
    chk("rw_enable", enable_cnt, 1);
    for (int i = 0; i < 4; i++) step();
    c = rsp_count;
    rst = 1'b1;
    step();
    rst = 1'b0; stub_cnt = 0; drop_next = 1'b0;
    step();
    chk("rw_busy", 32'(s_busy), 0);
    chk("rw_no_rsp", 32'(s_rsp_valid), 0);
    set_req(1, 3'd3, 8'h0F, 8'hFF);
    req_valid = 4'b0011;
    step();
    chk("rw_grant", 32'(s_req_ready), 32'h1);
    req_valid = req_valid & ~s_req_ready;
    run_to_rsp(20);
    chk("rw_rsp_vec", 32'(rsp_vec), 32'h1);
    chk("rw_rsp_count", rsp_count, c + 1);
    req_valid = '0;
    step(); step();

    // randomized traffic against the transaction model
    do_reset();
    m_busy = 1'b0; m_last = NR - 1; rand_mode = 1'b1;
    for (int t = 0; t < 2500; t++) begin
      step();
      for (int i = 0; i < NR; i++) begin
        if (s_req_ready[i]) req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          int v = $urandom_range(0, 9);
          case (v)
            6: r_op[i] = 3'd0;
            7: r_op[i] = 3'd5;
            8: r_op[i] = 3'd6;
            9: r_op[i] = 3'd7;
            default: r_op[i] = 3'((v % 4) + 1);
          endcase
          r_a[i] = 8'($urandom); r_b[i] = 8'($urandom);
          req_valid[i] = 1'b1;
        end else if (req_valid[i] && $urandom_range(0, 40) == 0) req_valid[i] = 1'b0;
      end
      pack();
      alu_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = '0; alu_ready = 1'b1;
    n = 0;
    while (m_busy && n < TO + 50) begin step(); n++; end
    rand_mode = 1'b0;
    chk("rnd_drained", 32'(m_busy), 0);

    summary();
    $finish;
  end

endmodule
